// File: rtl/hack_kbd_pkg.sv
// Shared constants for the PS/2 keyboard front end: Hack key codes,
// Set-2 prefix/modifier scan codes and the frame FSM encoding.
package hack_kbd_pkg;
   localparam logic [7:0] KEY_SPACE     = 8'd32;
   localparam logic [7:0] KEY_NEWLINE   = 8'd128;
   localparam logic [7:0] KEY_BACKSPACE = 8'd129;
   localparam logic [7:0] KEY_LEFT      = 8'd130;
   localparam logic [7:0] KEY_UP        = 8'd131;
   localparam logic [7:0] KEY_RIGHT     = 8'd132;
   localparam logic [7:0] KEY_DOWN      = 8'd133;
   localparam logic [7:0] KEY_HOME      = 8'd134;
   localparam logic [7:0] KEY_END       = 8'd135;
   localparam logic [7:0] KEY_PGUP      = 8'd136;
   localparam logic [7:0] KEY_PGDN      = 8'd137;
   localparam logic [7:0] KEY_INS       = 8'd138;
   localparam logic [7:0] KEY_DEL       = 8'd139;
   localparam logic [7:0] KEY_ESC       = 8'd140;
   localparam logic [7:0] KEY_F1        = 8'd141;
   localparam logic [7:0] KEY_F12       = 8'd152;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_st_t;
endpackage

// File: rtl/ps2_to_hack.sv
// Combinational Set-2 scan code to Hack key code table.
// Letters come out lower case unless shift is held.
module ps2_to_hack
   import hack_kbd_pkg::*;
(
   input  logic       ext,
   input  logic [7:0] scan,
   input  logic       shift,
   output logic       mapped,
   output logic [7:0] code
);
   logic [7:0] letter;

   always_comb begin
      mapped = 1'b1;
      code   = '0;
      letter = '0;
      if (ext) begin
         case (scan)
            8'h6B: code = KEY_LEFT;
            8'h75: code = KEY_UP;
            8'h74: code = KEY_RIGHT;
            8'h72: code = KEY_DOWN;
            8'h6C: code = KEY_HOME;
            8'h69: code = KEY_END;
            8'h7D: code = KEY_PGUP;
            8'h7A: code = KEY_PGDN;
            8'h70: code = KEY_INS;
            8'h71: code = KEY_DEL;
            default: mapped = 1'b0;
         endcase
      end else begin
         case (scan)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h45: code = "0";    8'h16: code = "1";    8'h1E: code = "2";
            8'h26: code = "3";    8'h25: code = "4";    8'h2E: code = "5";
            8'h36: code = "6";    8'h3D: code = "7";    8'h3E: code = "8";
            8'h46: code = "9";
            8'h29: code = KEY_SPACE;
            8'h5A: code = KEY_NEWLINE;
            8'h66: code = KEY_BACKSPACE;
            8'h76: code = KEY_ESC;
            8'h05: code = KEY_F1;
            8'h06: code = KEY_F1 + 8'd1;
            8'h04: code = KEY_F1 + 8'd2;
            8'h0C: code = KEY_F1 + 8'd3;
            8'h03: code = KEY_F1 + 8'd4;
            8'h0B: code = KEY_F1 + 8'd5;
            8'h83: code = KEY_F1 + 8'd6;
            8'h0A: code = KEY_F1 + 8'd7;
            8'h01: code = KEY_F1 + 8'd8;
            8'h09: code = KEY_F1 + 8'd9;
            8'h78: code = KEY_F1 + 8'd10;
            8'h07: code = KEY_F12;
            default: mapped = 1'b0;
         endcase
         if (letter != '0) code = shift ? letter - 8'd32 : letter;
      end
   end
endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 Set-2 receiver presenting the Hack KBD word (code of the held key, 0 = none).
// Pins are synchronised, ps2_clk is glitch filtered, frames are decoded on filtered falls.
module ps2_keyboard
   import hack_kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] kbd_out,
   output logic        frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall, din;

   frame_st_t     state;
   logic [7:0]    sh;
   logic [2:0]    bit_cnt;
   logic          par, byte_vld;
   logic [TW-1:0] idle_cnt;

   logic          ext, brk, shift;
   logic          map_hit, key_match, is_letter;
   logic [7:0]    map_code;

   assign din  = dat_sync[1];
   assign fall = clk_filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));

   // Lines idle high, so the synchronisers and filter come out of reset high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         if (clk_sync[1] == clk_filt) filt_cnt <= '0;
         else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
         end else filt_cnt <= filt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         sh        <= '0;
         bit_cnt   <= '0;
         par       <= 1'b0;
         idle_cnt  <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            case (state)
               ST_IDLE:   if (!din) begin state <= ST_DATA; bit_cnt <= '0; end
               ST_DATA: begin
                  sh      <= {din, sh[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin par <= din; state <= ST_STOP; end
               ST_STOP: begin
                  if (din && ^{sh, par}) byte_vld <= 1'b1;
                  else frame_err <= 1'b1;
                  state <= ST_IDLE;
               end
            endcase
         end else if (state != ST_IDLE) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state     <= ST_IDLE;
               frame_err <= 1'b1;
               idle_cnt  <= '0;
            end else idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

   // sh holds the delivered byte while byte_vld is high: no new bits arrive until the next frame.
   ps2_to_hack u_map (
      .ext    (ext),
      .scan   (sh),
      .shift  (shift),
      .mapped (map_hit),
      .code   (map_code)
   );

   // A break matches the held letter in either case, so shift released first still clears it.
   assign is_letter = (map_code >= "a" && map_code <= "z") || (map_code >= "A" && map_code <= "Z");
   assign key_match = (map_code == kbd_out[7:0]) ||
                      (is_letter && ((map_code ^ 8'h20) == kbd_out[7:0]));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kbd_out <= '0;
         ext     <= 1'b0;
         brk     <= 1'b0;
         shift   <= 1'b0;
      end else if (frame_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_vld) begin
         if (sh == PS2_EXT) ext <= 1'b1;
         else if (sh == PS2_BRK) brk <= 1'b1;
         else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (sh == PS2_LSHIFT || sh == PS2_RSHIFT) shift <= !brk;
            else if (map_hit) begin
               if (!brk) kbd_out <= {8'h00, map_code};
               else if (key_match) kbd_out <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames and compares kbd_out every
// cycle against a key-event model built from scan-code tables.
module tb_ps2_keyboard;
   localparam int HALF = 24;
   localparam int TMO  = 200;

   logic        clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [15:0] kbd_out;
   logic        frame_err;

   ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .kbd_out(kbd_out), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0, err_seen = 0, exp_err = 0, n_msg = 0;
   bit chk_en = 1'b0, prev_err = 1'b0;
   bit m_ext = 1'b0, m_brk = 1'b0, m_shift = 1'b0;
   logic [15:0] m_kbd = '0;
   int map_n[logic [7:0]];
   int map_e[logic [7:0]];

   logic [7:0] let_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                               8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                               8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] dig_sc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   logic [7:0] fk_sc  [12] = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
   logic [7:0] nav_sc [10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lookup(input bit e, input logic [7:0] s, input bit sh);
      int c;
      c = -1;
      if (e) begin
         if (map_e.exists(s)) c = map_e[s];
      end else if (map_n.exists(s)) c = map_n[s];
      if (sh && c >= 97 && c <= 122) c -= 32;
      return c;
   endfunction

   function automatic int lc(input int x);
      return (x >= 65 && x <= 90) ? x + 32 : x;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int c;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         c = lookup(m_ext, b, m_shift);
         if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
         else if (c >= 0) begin
            if (!m_brk) m_kbd = 16'(c);
            else if (lc(c) == lc(int'(m_kbd))) m_kbd = '0;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   // Sends the first nbits of a frame; a full frame updates the model once the byte has landed.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                             input bit glitch, input bit lat, input logic [15:0] lat_new);
      logic [10:0] fr;
      logic [15:0] old;
      fr = {1'b1, bad_par ? ^b : ~^b, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); ps2_data = fr[i];
         if (glitch) begin
            repeat (12) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 15) @(negedge clk);
         end else repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            chk_en = 1'b0;
            old = m_kbd;
            if (lat) begin
               repeat (10) @(posedge clk);
               #1 chk("latency_before", kbd_out, old);
               @(posedge clk);
               #1 chk("latency_two_cycles", kbd_out, lat_new);
            end else repeat (11) @(posedge clk);
            if (bad_par) begin
               m_ext = 1'b0; m_brk = 1'b0; exp_err++;
            end else model_byte(b);
            chk_en = 1'b1;
            repeat (HALF - 11) @(negedge clk);
         end else repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic key(input logic [7:0] b);
      send_frame(b, 1'b0, 11, 1'b0, 1'b0, 16'd0);
   endtask

   initial begin
      forever @(negedge clk) begin
         if (chk_en) begin
            n_assert++;
            if (kbd_out !== m_kbd) begin
               n_fail++;
               if (n_msg < 20) $display("FAIL kbd_cycle: kbd_out=%0d, model=%0d (t=%0t)", kbd_out, m_kbd, $time);
               n_msg++;
            end
         end
         if (frame_err) begin
            n_assert++;
            if (prev_err) begin
               n_fail++;
               $display("FAIL frame_err_width: high 2+ cycles, required 1 (t=%0t)", $time);
            end else err_seen++;
         end
         prev_err = frame_err;
      end
   end

   initial begin
      for (int i = 0; i < 26; i++) map_n[let_sc[i]] = 97 + i;
      for (int i = 0; i < 10; i++) map_n[dig_sc[i]] = 48 + i;
      for (int i = 0; i < 12; i++) map_n[fk_sc[i]] = 141 + i;
      for (int i = 0; i < 10; i++) map_e[nav_sc[i]] = 130 + i;
      map_n[8'h29] = 32; map_n[8'h5A] = 128; map_n[8'h66] = 129; map_n[8'h76] = 140;

      repeat (3) @(posedge clk);
      #1 chk("reset_kbd", kbd_out, 16'd0);
      chk("reset_err", {15'd0, frame_err}, 16'd0);
      @(negedge clk) reset = 1'b1;
      repeat (5) @(negedge clk);
      chk_en = 1'b1;

      // make / break of a letter, with cycle-exact latency on the make
      send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b1, 16'd97);
      chk("t1_make_a", kbd_out, 16'd97);
      key(8'hF0); key(8'h1C);
      chk("t1_break_a", kbd_out, 16'd0);

      // shifted letters, shift released before the letter
      key(8'h12); key(8'h1C);
      chk("t2_shift_a", kbd_out, 16'd65);
      key(8'hF0); key(8'h12);
      chk("t2_shift_rel", kbd_out, 16'd65);
      key(8'hF0); key(8'h1C);
      chk("t2_break_A", kbd_out, 16'd0);
      key(8'h59); key(8'h1A);
      chk("t2_rshift_z", kbd_out, 16'd90);
      key(8'hF0); key(8'h59); key(8'hF0); key(8'h1A);
      chk("t2_break_Z", kbd_out, 16'd0);

      // extended keys and unmapped keypad code
      key(8'hE0); key(8'h75);
      chk("t3_up", kbd_out, 16'd131);
      key(8'hE0); key(8'hF0); key(8'h75);
      chk("t3_up_break", kbd_out, 16'd0);
      key(8'h1C); key(8'h75);
      chk("t3_kp8_ignored", kbd_out, 16'd97);

      // parity errors, and an error clearing a pending E0
      key(8'h29);
      chk("t4_space", kbd_out, 16'd32);
      send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0, 16'd0);
      chk("t4_bad_par_kbd", kbd_out, 16'd32);
      chk("t4_bad_par_err", 16'(err_seen), 16'd1);
      key(8'hE0);
      send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0, 16'd0);
      key(8'h75);
      chk("t4_ext_cleared", kbd_out, 16'd32);
      key(8'h1C);
      chk("t4_good_a", kbd_out, 16'd97);

      // truncated frame aborted by timeout
      send_frame(8'h1C, 1'b0, 5, 1'b0, 1'b0, 16'd0);
      repeat (TMO + 50) @(negedge clk);
      exp_err++;
      chk("t5_timeout_err", 16'(err_seen), 16'd3);
      key(8'h29);
      chk("t5_space", kbd_out, 16'd32);

      // spread of the map; breaks of keys not held are ignored
      key(8'hE0); key(8'h6B); chk("map_left", kbd_out, 16'd130);
      key(8'h03); chk("map_f5", kbd_out, 16'd145);
      key(8'h45); chk("map_0", kbd_out, 16'd48);
      key(8'h5A); chk("map_enter", kbd_out, 16'd128);
      key(8'h83); chk("map_f7", kbd_out, 16'd147);
      key(8'h07); chk("map_f12", kbd_out, 16'd152);
      key(8'hF0); key(8'h1C); chk("break_other", kbd_out, 16'd152);
      key(8'hE0); key(8'hF0); key(8'h71); chk("break_del_other", kbd_out, 16'd152);

      // glitchy clock, typematic repeat, reset mid-frame
      send_frame(8'h1C, 1'b0, 11, 1'b1, 1'b0, 16'd0);
      chk("t6_glitch_a", kbd_out, 16'd97);
      key(8'h1C);
      chk("t6_repeat_a", kbd_out, 16'd97);
      send_frame(8'h32, 1'b0, 4, 1'b0, 1'b0, 16'd0);
      chk_en = 1'b0;
      @(negedge clk) reset = 1'b0;
      #1 chk("t6_async_reset", kbd_out, 16'd0);
      m_kbd = '0; m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      key(8'h1C);
      chk("t6_after_reset", kbd_out, 16'd97);

      chk("err_total", 16'(err_seen), 16'd3);
      chk("err_vs_model", 16'(err_seen), 16'(exp_err));
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
